// File: rtl/serializer_tx.sv
// serializer_tx: FIFO-buffered UART-style serializer (start 0, MSB-first data, stop 1)
module serializer_tx #(
    parameter int PKT_W      = 8,
    parameter int DEPTH      = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [PKT_W-1:0]           io_pIn,
    input  logic                       io_wrEn,
    output logic                       io_full,
    output logic [$clog2(DEPTH+1)-1:0] io_count,
    output logic                       io_overflow,
    output logic                       io_sOut,
    output logic                       io_busy
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int BCW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam int PBW = PKT_W > 1 ? $clog2(PKT_W) : 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t           r_state;
    logic [PKT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_count;
    logic [PKT_W-1:0] r_sh;
    logic [BCW-1:0]   r_cyc;
    logic [PBW-1:0]   r_bit;
    logic             r_ovf, r_sout;
    logic             w_full, w_push, w_pop, w_bit_end, w_line;
    always_comb begin
        w_full      = r_count == CW'(DEPTH);
        w_push      = io_wrEn && !w_full;
        w_bit_end   = r_cyc == BCW'(BIT_CYCLES - 1);
        w_pop       = (r_count != '0) && (r_state == IDLE || (r_state == STOP && w_bit_end));
        w_line      = (r_state == START) ? 1'b0 : (r_state == DATA) ? r_sh[PKT_W-1] : 1'b1;
        io_full     = w_full;
        io_count    = r_count;
        io_overflow = r_ovf;
        io_sOut     = r_sout;
        io_busy     = (r_state != IDLE) || (r_count != '0);
    end
    // io_sOut lags the state by one edge, giving the two-edge write-to-start latency
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_sh    <= '0;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_ovf   <= 1'b0;
            r_sout  <= 1'b1;
        end else begin
            r_ovf   <= io_wrEn && w_full;
            r_sout  <= w_line;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_cyc   <= (r_state == IDLE || w_bit_end) ? '0 : r_cyc + 1'b1;
            if (w_push) begin
                r_mem[r_wp] <= io_pIn;
                r_wp        <= r_wp + 1'b1;
            end
            case (r_state)
                IDLE:  if (w_pop) r_state <= START;
                START: if (w_bit_end) r_state <= DATA;
                DATA:  if (w_bit_end) begin
                    r_sh  <= r_sh << 1;
                    r_bit <= (r_bit == PBW'(PKT_W - 1)) ? '0 : r_bit + 1'b1;
                    if (r_bit == PBW'(PKT_W - 1)) r_state <= STOP;
                end
                STOP:  if (w_bit_end) r_state <= w_pop ? START : IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_pop) begin
                r_sh <= r_mem[r_rp];
                r_rp <= r_rp + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serializer_tx.sv
// tb_serializer_tx: two lanes (BIT_CYCLES 1 and 3) checked against a frame-timeline model and a serial decoder
module tb_serializer_tx;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          wr = 1'b0;
    logic [7:0]    din = '0;
    logic [1:0]    w_full, w_ovf, w_so, w_busy;
    logic [CW-1:0] w_cnt [2];
    bit            armed = 1'b0;
    int            errors = 0;
    int            checks = 0;
    always #5 clock = ~clock;
    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s lane%0d: got %0h expected %0h", nm, g, act, exp);
        end
    endtask
    for (genvar g = 0; g < 2; g++) begin : ln
        localparam int BC = g == 0 ? 1 : 3;
        localparam int L  = 10 * BC;
        logic [7:0] q[$];
        logic [7:0] sb[$];
        bit         lq[$];
        int         t = 0;
        bit         e_so = 1'b1, e_ovf = 1'b0, rst_seen = 1'b1;
        bit         pop, acc, inf = 1'b0;
        logic [7:0] d, rsh;
        int         mc;
        serializer_tx #(.PKT_W(8), .DEPTH(DEPTH), .BIT_CYCLES(BC)) dut (
            .clock(clock), .reset(reset), .io_pIn(din), .io_wrEn(wr),
            .io_full(w_full[g]), .io_count(w_cnt[g]), .io_overflow(w_ovf[g]),
            .io_sOut(w_so[g]), .io_busy(w_busy[g])
        );
        // model: transmitter is busy for L cycles per frame and takes the next packet on its last cycle
        always @(posedge clock) begin
            rst_seen = !reset;
            if (!reset) begin
                q.delete();
                sb.delete();
                lq.delete();
                t = 0;
                e_so = 1'b1;
                e_ovf = 1'b0;
            end else begin
                pop   = q.size() != 0 && t <= 1;
                acc   = wr && q.size() < DEPTH;
                e_ovf = wr && q.size() == DEPTH;
                e_so  = lq.size() != 0 ? lq.pop_front() : 1'b1;
                if (pop) begin
                    d = q.pop_front();
                    t = L;
                    for (int k = 0; k < BC; k++) lq.push_back(1'b0);
                    for (int i = 7; i >= 0; i--) for (int k = 0; k < BC; k++) lq.push_back(d[i]);
                    for (int k = 0; k < BC; k++) lq.push_back(1'b1);
                end else if (t > 0) t--;
                if (acc) begin
                    q.push_back(din);
                    sb.push_back(din);
                end
            end
        end
        always @(negedge clock) begin
            if (armed) begin
                chk("sOut", g, 32'(w_so[g]), 32'(e_so));
                chk("count", g, 32'(w_cnt[g]), q.size());
                chk("full", g, 32'(w_full[g]), 32'(q.size() == DEPTH));
                chk("overflow", g, 32'(w_ovf[g]), 32'(e_ovf));
                chk("busy", g, 32'(w_busy[g]), 32'(t != 0 || q.size() != 0));
            end
        end
        // decoder: samples each bit at its centre and scores the packet against the accepted-write queue
        always @(negedge clock) begin
            if (!armed || rst_seen) inf = 1'b0;
            else if (!inf) begin
                if (w_so[g] == 1'b0) begin
                    inf = 1'b1;
                    mc = 0;
                end
            end else begin
                mc++;
                for (int i = 0; i < 8; i++) if (mc == BC * (1 + i) + BC / 2) rsh[7 - i] = w_so[g];
                if (mc == BC * 9 + BC / 2) begin
                    inf = 1'b0;
                    chk("stop bit", g, 32'(w_so[g]), 32'd1);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx unexpected lane%0d: got %0h expected no frame", g, rsh);
                    end else chk("rx data", g, 32'(rsh), 32'(sb.pop_front()));
                end
            end
        end
    end
    task automatic step(input bit w, input logic [7:0] v);
        @(negedge clock);
        wr = w;
        din = v;
    endtask
    initial begin
        logic [11:0] cap;
        logic [7:0]  burst [6];
        burst = '{8'hFF, 8'h00, 8'h3C, 8'h81, 8'h5A, 8'hC3};
        repeat (2) @(negedge clock);
        armed = 1'b1;
        chk("reset sOut", 0, 32'(w_so[0]), 32'd1);
        chk("reset busy", 0, 32'(w_busy[0]), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 8'hA5);
        step(1'b0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clock);
            cap[11 - i] = w_so[0];
        end
        chk("A5 waveform", 0, 32'(cap), 32'(12'b110101001011));
        @(negedge clock);
        chk("A5 busy after stop", 0, 32'(w_busy[0]), 32'd0);
        repeat (30) step(1'b0, 8'h00);
        foreach (burst[i]) step(1'b1, burst[i]);
        step(1'b0, 8'h00);
        repeat (200) step(1'b0, 8'h00);
        step(1'b1, 8'h55);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b0, 8'h00);
        repeat (5) step(1'b0, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        wr = 1'b1;
        din = 8'h99;
        @(negedge clock);
        reset = 1'b1;
        wr = 1'b0;
        chk("abort sOut", 0, 32'(w_so[0]), 32'd1);
        chk("abort count", 0, 32'(w_cnt[0]), 32'd0);
        chk("abort busy", 1, 32'(w_busy[1]), 32'd0);
        repeat (40) step(1'b0, 8'h00);
        for (int n = 0; n < 150; n++) begin
            step(1'b1, 8'($urandom));
            if ($urandom_range(0, 9) == 0) repeat (5) step(1'b1, 8'($urandom));
            repeat ($urandom_range(0, 14)) step(1'b0, 8'h00);
        end
        step(1'b0, 8'h00);
        repeat (400) step(1'b0, 8'h00);
        chk("drained", 0, ln[0].sb.size(), 32'd0);
        chk("drained", 1, ln[1].sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
